// File: rtl/dcache_responder_pkg.sv
// Shared constants, FSM state encodings and line layout for dcache_responder.
package dcache_responder_pkg;

    localparam int unsigned DC_XLEN           = 64;
    localparam int unsigned DC_NR_SETS        = 64;
    localparam int unsigned DC_CACHELINE_SIZE = 64;
    localparam int unsigned DC_LINE_WORDS     = DC_CACHELINE_SIZE / 8;
    localparam int unsigned DC_OFFSET_W       = $clog2(DC_CACHELINE_SIZE);
    localparam int unsigned DC_INDEX_W        = $clog2(DC_NR_SETS);
    localparam int unsigned DC_TAG_W          = DC_XLEN - DC_OFFSET_W - DC_INDEX_W;
    localparam int unsigned DC_BEAT_W         = $clog2(DC_LINE_WORDS);

    typedef logic [1:0] dcache_state_t;
    localparam dcache_state_t ST_IDLE        = 2'd0;
    localparam dcache_state_t ST_REFILL_REQ  = 2'd1;
    localparam dcache_state_t ST_REFILL_WAIT = 2'd2;
    localparam dcache_state_t ST_RESPOND     = 2'd3;

    typedef struct packed {
        logic                                  valid;
        logic [DC_TAG_W-1:0]                   tag;
        logic [DC_LINE_WORDS-1:0][DC_XLEN-1:0] data;
    } dcache_line_t;

endpackage

// File: rtl/dcache_responder_refill_fsm.sv
// Refill sequencer: state register, beat counter, line-read request and RESPOND strobe.
module dcache_refill_fsm
    import dcache_responder_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned BEAT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_i,
    input  logic [XLEN-1:0]   line_addr_i,
    input  logic              mem_req_ready_i,
    input  logic              mem_rsp_valid_i,
    output dcache_state_t     state_o,
    output logic              rd_req_valid_o,
    output logic [XLEN-1:0]   rd_req_addr_o,
    output logic [BEAT_W-1:0] beat_o,
    output logic              beat_we_o,
    output logic              last_beat_o,
    output logic              respond_o
);

    dcache_state_t     state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [XLEN-1:0]   line_q, line_d;

    assign beat_we_o      = (state_q == ST_REFILL_WAIT) && mem_rsp_valid_i;
    assign last_beat_o    = beat_we_o && (beat_q == '1);
    assign rd_req_valid_o = (state_q == ST_REFILL_REQ);
    assign rd_req_addr_o  = line_q;
    assign respond_o      = (state_q == ST_RESPOND);
    assign state_o        = state_q;
    assign beat_o         = beat_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_i) begin
                    state_d = ST_REFILL_REQ;
                    line_d  = line_addr_i;
                end
            end
            ST_REFILL_REQ: begin
                if (mem_req_ready_i) state_d = ST_REFILL_WAIT;
            end
            ST_REFILL_WAIT: begin
                // counter wraps to 0 on the last beat, ready for the next refill
                if (mem_rsp_valid_i) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == '1) state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-through, no-write-allocate data cache responder (one outstanding miss).
// Optional hit/miss performance counters enabled by defining DCACHE_PERF_CNT_EN.
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int unsigned NR_SETS        = 64,
    parameter int unsigned CACHELINE_SIZE = 64,
    parameter int unsigned XLEN           = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wvalid,
    output logic            wready,
    input  logic [XLEN-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [7:0]      wmask,
    input  logic            load_a_valid,
    output logic            load_a_ready,
    input  logic [XLEN-1:0] load_a_addr,
    output logic            load_d_valid,
    output logic [XLEN-1:0] load_d_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_we,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [31:0]     hit_cnt,
    output logic [31:0]     miss_cnt
);

    localparam int unsigned WORDS  = CACHELINE_SIZE / 8;
    localparam int unsigned OFF_W  = $clog2(CACHELINE_SIZE);
    localparam int unsigned IDX_W  = $clog2(NR_SETS);
    localparam int unsigned TAG_W  = XLEN - OFF_W - IDX_W;
    localparam int unsigned BEAT_W = $clog2(WORDS);

    logic [NR_SETS-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [NR_SETS];
    logic [XLEN-1:0]    data_q [NR_SETS][WORDS];

    logic [IDX_W-1:0]  req_idx_q;
    logic [TAG_W-1:0]  req_tag_q;
    logic [BEAT_W-1:0] req_beat_q;
    logic              hit_rsp_q;
    logic [XLEN-1:0]   rdata_q;

    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_w,
                                                    input logic [XLEN-1:0] new_w,
                                                    input logic [7:0]      mask);
        merge_bytes = old_w;
        for (int unsigned b = 0; b < 8; b++)
            if (mask[b]) merge_bytes[8*b +: 8] = new_w[8*b +: 8];
    endfunction

    logic [IDX_W-1:0]  ld_idx, st_idx;
    logic [TAG_W-1:0]  ld_tag, st_tag;
    logic [BEAT_W-1:0] ld_beat, st_beat;
    assign ld_idx  = load_a_addr[OFF_W +: IDX_W];
    assign ld_tag  = load_a_addr[XLEN-1 -: TAG_W];
    assign ld_beat = load_a_addr[3 +: BEAT_W];
    assign st_idx  = waddr[OFF_W +: IDX_W];
    assign st_tag  = waddr[XLEN-1 -: TAG_W];
    assign st_beat = waddr[3 +: BEAT_W];

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{load_a_addr[2:0], waddr[2:0]};

    dcache_state_t     state;
    logic              rd_req_valid, beat_we, last_beat, respond;
    logic [XLEN-1:0]   rd_req_addr;
    logic [BEAT_W-1:0] beat;
    logic              idle;
    assign idle = (state == ST_IDLE);

    logic ld_hit, st_hit, load_acc, load_hit_acc, load_miss_acc, st_acc, same_dw;
    logic [XLEN-1:0] st_merged, ld_word;

    assign load_a_ready  = idle && !rst;
    assign wready        = idle && mem_req_ready && !rst;
    assign ld_hit        = valid_q[ld_idx] && (tag_q[ld_idx] == ld_tag);
    assign st_hit        = valid_q[st_idx] && (tag_q[st_idx] == st_tag);
    assign load_acc      = load_a_valid && load_a_ready;
    assign load_hit_acc  = load_acc && ld_hit;
    assign load_miss_acc = load_acc && !ld_hit;
    assign st_acc        = wvalid && wready;
    assign st_merged     = merge_bytes(data_q[st_idx][st_beat], wdata, wmask);
    // a same-cycle store hit to the loaded doubleword is forwarded into the hit data
    assign same_dw       = st_acc && st_hit && (st_idx == ld_idx) && (st_beat == ld_beat)
                           && (st_tag == ld_tag);
    assign ld_word       = same_dw ? st_merged : data_q[ld_idx][ld_beat];

    dcache_refill_fsm #(
        .XLEN   (XLEN),
        .BEAT_W (BEAT_W)
    ) u_refill_fsm (
        .clk             (clk),
        .rst             (rst),
        .miss_i          (load_miss_acc),
        .line_addr_i     ({ld_tag, ld_idx, {OFF_W{1'b0}}}),
        .mem_req_ready_i (mem_req_ready),
        .mem_rsp_valid_i (mem_rsp_valid),
        .state_o         (state),
        .rd_req_valid_o  (rd_req_valid),
        .rd_req_addr_o   (rd_req_addr),
        .beat_o          (beat),
        .beat_we_o       (beat_we),
        .last_beat_o     (last_beat),
        .respond_o       (respond)
    );

    assign mem_req_wdata = wdata;
    assign mem_req_wmask = wmask;

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        if (!rst) begin
            if (idle) begin
                mem_req_valid = wvalid;
                mem_req_we    = 1'b1;
                mem_req_addr  = {waddr[XLEN-1:3], 3'b000};
            end else if (rd_req_valid) begin
                mem_req_valid = 1'b1;
                mem_req_addr  = rd_req_addr;
            end
        end
    end

    assign load_d_valid = !rst && (hit_rsp_q || respond);
    assign load_d_data  = rst     ? '0 :
                          respond ? data_q[req_idx_q][req_beat_q] : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            hit_rsp_q  <= 1'b0;
            rdata_q    <= '0;
            req_idx_q  <= '0;
            req_tag_q  <= '0;
            req_beat_q <= '0;
        end else begin
            hit_rsp_q <= load_hit_acc;
            if (load_hit_acc) rdata_q <= ld_word;
            if (load_miss_acc) begin
                req_idx_q  <= ld_idx;
                req_tag_q  <= ld_tag;
                req_beat_q <= ld_beat;
                valid_q[ld_idx] <= 1'b0;
            end
            if (last_beat) valid_q[req_idx_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (st_acc && st_hit) data_q[st_idx][st_beat] <= st_merged;
        if (beat_we)          data_q[req_idx_q][beat] <= mem_rsp_data;
        if (last_beat)        tag_q[req_idx_q]        <= req_tag_q;
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (load_hit_acc && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (load_miss_acc && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a beat-serving memory model.
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        wvalid, wready;
    logic [63:0] waddr, wdata;
    logic [7:0]  wmask;
    logic        load_a_valid, load_a_ready;
    logic [63:0] load_a_addr;
    logic        load_d_valid;
    logic [63:0] load_d_data;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;
    logic [31:0] hit_cnt, miss_cnt;

    int vectors = 0;
    int miscompares = 0;

`ifdef DCACHE_PERF_CNT_EN
    localparam logic [31:0] EXP_ONE = 32'd1;
`else
    localparam logic [31:0] EXP_ONE = 32'd0;
`endif

    always #5 clk = ~clk;

    dcache_responder #(
        .NR_SETS        (64),
        .CACHELINE_SIZE (64),
        .XLEN           (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wvalid        (wvalid),
        .wready        (wready),
        .waddr         (waddr),
        .wdata         (wdata),
        .wmask         (wmask),
        .load_a_valid  (load_a_valid),
        .load_a_ready  (load_a_ready),
        .load_a_addr   (load_a_addr),
        .load_d_valid  (load_d_valid),
        .load_d_data   (load_d_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    // backing memory: explicit entries, otherwise a unique address-derived word
    logic [63:0] mem [logic [63:0]];
    logic [63:0] rd_line;
    int          rd_i = 0;
    int          rd_left = 0;

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 64'hC0DE_0000_0000_0000 | a;
    endfunction

    function automatic logic [63:0] byte_merge(input logic [63:0] o, input logic [63:0] n,
                                               input logic [7:0] m);
        logic [63:0] r;
        r = o;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
            if (mem_req_we)
                mem[mem_req_addr] = byte_merge(mem_read(mem_req_addr), mem_req_wdata, mem_req_wmask);
            else begin
                rd_line = mem_req_addr;
                rd_i    = 0;
                rd_left = 8;
            end
        end
        #1;
        if (rd_left > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_read(rd_line + 64'(8 * rd_i));
            rd_i++;
            rd_left--;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    end

    task automatic wait_load_d(input int max_cycles, output bit got, output logic [63:0] d);
        got = 1'b0;
        d   = '0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            if (load_d_valid === 1'b1) begin
                got = 1'b1;
                d   = load_d_data;
            end else @(negedge clk);
        end
    endtask

    task automatic issue_load(input logic [63:0] a);
        load_a_valid = 1'b1;
        load_a_addr  = a;
        @(negedge clk);
        load_a_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; wvalid = 1'b1; waddr = 64'h1000; wdata = '0; wmask = 8'hFF;
        load_a_valid = 1'b1; load_a_addr = 64'h1000; mem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (wready !== 1'b0) begin miscompares++; $display("FAIL rst_wready got=%b exp=0", wready); end
        vectors++; if (load_a_ready !== 1'b0) begin miscompares++; $display("FAIL rst_load_a_ready got=%b exp=0", load_a_ready); end
        vectors++; if (load_d_valid !== 1'b0) begin miscompares++; $display("FAIL rst_load_d_valid got=%b exp=0", load_d_valid); end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req_valid got=%b exp=0", mem_req_valid); end
        vectors++; if (load_d_data !== 64'h0) begin miscompares++; $display("FAIL rst_load_d_data got=%h exp=0", load_d_data); end
        vectors++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin miscompares++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
        wvalid = 1'b0; load_a_valid = 1'b0; rst = 1'b0;
        #1;
        vectors++; if (load_a_ready !== 1'b1 || wready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready got=%b%b exp=11", load_a_ready, wready); end
        @(negedge clk);
    endtask

    task automatic test_cold_miss;
        bit got; logic [63:0] d;
        load_a_valid = 1'b1; load_a_addr = 64'h1000;
        #1;
        vectors++; if (load_a_ready !== 1'b1) begin miscompares++; $display("FAIL cold_accept got=%b exp=1", load_a_ready); end
        @(negedge clk);
        load_a_valid = 1'b0;
        vectors++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 64'h1000) begin
            miscompares++; $display("FAIL cold_req got=v%b we%b a%h exp=v1 we0 a1000", mem_req_valid, mem_req_we, mem_req_addr); end
        wait_load_d(40, got, d);
        vectors++; if (!got) begin miscompares++; $display("FAIL cold_timeout got=no_rsp exp=rsp"); end
        vectors++; if (d !== 64'hA0) begin miscompares++; $display("FAIL cold_data got=%h exp=a0", d); end
        vectors++; if (wready !== 1'b0 || load_a_ready !== 1'b0) begin miscompares++; $display("FAIL respond_stall got=%b%b exp=00", wready, load_a_ready); end
        @(negedge clk);
        issue_load(64'h1008);
        vectors++; if (load_d_valid !== 1'b1 || load_d_data !== 64'hA1) begin
            miscompares++; $display("FAIL hit_1008 got=v%b d%h exp=v1 da1", load_d_valid, load_d_data); end
        vectors++; if (hit_cnt !== EXP_ONE || miss_cnt !== EXP_ONE) begin
            miscompares++; $display("FAIL counters got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, EXP_ONE, EXP_ONE); end
        @(negedge clk);
        vectors++; if (load_d_valid !== 1'b0) begin miscompares++; $display("FAIL hit_single_pulse got=%b exp=0", load_d_valid); end
    endtask

    task automatic test_store_hit;
        wvalid = 1'b1; waddr = 64'h1000; wdata = 64'h11; wmask = 8'h01;
        #1;
        vectors++; if (wready !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 64'h1000 || mem_req_wdata !== 64'h11) begin
            miscompares++; $display("FAIL store_req got=r%b v%b we%b a%h d%h exp=r1 v1 we1 a1000 d11", wready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata); end
        @(negedge clk);
        wvalid = 1'b0;
        issue_load(64'h1000);
        vectors++; if (load_d_valid !== 1'b1 || load_d_data !== 64'h11) begin
            miscompares++; $display("FAIL store_merge got=v%b d%h exp=v1 d11", load_d_valid, load_d_data); end
    endtask

    task automatic test_same_cycle;
        wvalid = 1'b1; waddr = 64'h1010; wdata = 64'h5555; wmask = 8'hFF;
        load_a_valid = 1'b1; load_a_addr = 64'h1010;
        #1;
        vectors++; if (wready !== 1'b1) begin miscompares++; $display("FAIL same_wready got=%b exp=1", wready); end
        @(negedge clk);
        wvalid = 1'b0; load_a_valid = 1'b0;
        vectors++; if (load_d_valid !== 1'b1 || load_d_data !== 64'h5555) begin
            miscompares++; $display("FAIL same_fwd got=v%b d%h exp=v1 d5555", load_d_valid, load_d_data); end
        issue_load(64'h1010);
        vectors++; if (load_d_valid !== 1'b1 || load_d_data !== 64'h5555) begin
            miscompares++; $display("FAIL same_array got=v%b d%h exp=v1 d5555", load_d_valid, load_d_data); end
    endtask

    task automatic test_store_miss_order;
        bit got; logic [63:0] d;
        wvalid = 1'b1; waddr = 64'h5000; wdata = 64'h77; wmask = 8'hFF;
        load_a_valid = 1'b1; load_a_addr = 64'h5000;
        #1;
        vectors++; if (wready !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 64'h5000) begin
            miscompares++; $display("FAIL order_store got=r%b v%b we%b a%h exp=r1 v1 we1 a5000", wready, mem_req_valid, mem_req_we, mem_req_addr); end
        @(negedge clk);
        wvalid = 1'b0; load_a_valid = 1'b0;
        vectors++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 64'h5000) begin
            miscompares++; $display("FAIL order_refill got=v%b we%b a%h exp=v1 we0 a5000", mem_req_valid, mem_req_we, mem_req_addr); end
        wait_load_d(40, got, d);
        vectors++; if (!got || d !== 64'h77) begin miscompares++; $display("FAIL order_data got=%0d/%h exp=1/77", got, d); end
        @(negedge clk);
    endtask

    task automatic test_stall;
        bit got;
        mem_req_ready = 1'b0;
        load_a_valid = 1'b1; load_a_addr = 64'h3040;
        @(negedge clk);
        load_a_valid = 1'b0;
        wvalid = 1'b1; waddr = 64'h3040; wdata = 64'hFFFF; wmask = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 64'h3040 || wready !== 1'b0 || load_a_ready !== 1'b0) begin
                miscompares++; $display("FAIL stall_hold[%0d] got=v%b we%b a%h r%b%b exp=v1 we0 a3040 r00", i, mem_req_valid, mem_req_we, mem_req_addr, wready, load_a_ready); end
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (load_d_valid === 1'b1) got = 1'b1;
            else begin
                vectors++; if (wready !== 1'b0 || load_a_ready !== 1'b0) begin
                    miscompares++; $display("FAIL stall_ready[%0d] got=%b%b exp=00", i, wready, load_a_ready); end
                @(negedge clk);
            end
        end
        vectors++; if (!got || load_d_data !== 64'hC0DE_0000_0000_3040) begin
            miscompares++; $display("FAIL stall_data got=%0d/%h exp=1/c0de000000003040", got, load_d_data); end
        vectors++; if (wready !== 1'b0 || load_a_ready !== 1'b0) begin miscompares++; $display("FAIL stall_respond got=%b%b exp=00", wready, load_a_ready); end
        wvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_evict;
        bit got; logic [63:0] d;
        issue_load(64'h1000);
        wait_load_d(40, got, d);
        vectors++; if (!got || d !== 64'h11) begin miscompares++; $display("FAIL evict_first got=%0d/%h exp=1/11", got, d); end
        @(negedge clk);
        issue_load(64'h2000);
        vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h2000) begin
            miscompares++; $display("FAIL evict_second_miss got=v%b a%h exp=v1 a2000", mem_req_valid, mem_req_addr); end
        wait_load_d(40, got, d);
        vectors++; if (!got || d !== 64'hC0DE_0000_0000_2000) begin miscompares++; $display("FAIL evict_second got=%0d/%h exp=1/c0de000000002000", got, d); end
        @(negedge clk);
        issue_load(64'h1000);
        vectors++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 64'h1000 || load_d_valid !== 1'b0) begin
            miscompares++; $display("FAIL evict_remiss got=v%b we%b a%h dv%b exp=v1 we0 a1000 dv0", mem_req_valid, mem_req_we, mem_req_addr, load_d_valid); end
        wait_load_d(40, got, d);
        vectors++; if (!got || d !== 64'h11) begin miscompares++; $display("FAIL evict_third got=%0d/%h exp=1/11", got, d); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_refill;
        bit got; logic [63:0] d; int seen;
        issue_load(64'h4080);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (rd_i == 4 && mem_rsp_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        vectors++; if (!got) begin miscompares++; $display("FAIL midrst_beats got=%0d exp=4", rd_i); end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (2) begin @(negedge clk); if (load_d_valid !== 1'b0) seen++; end
        rst = 1'b0;
        repeat (10) begin @(negedge clk); if (load_d_valid !== 1'b0) seen++; end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL midrst_no_rsp got=%0d exp=0", seen); end
        issue_load(64'h4080);
        vectors++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 64'h4080 || load_d_valid !== 1'b0) begin
            miscompares++; $display("FAIL midrst_remiss got=v%b we%b a%h dv%b exp=v1 we0 a4080 dv0", mem_req_valid, mem_req_we, mem_req_addr, load_d_valid); end
        wait_load_d(40, got, d);
        vectors++; if (!got || d !== 64'hC0DE_0000_0000_4080) begin miscompares++; $display("FAIL midrst_data got=%0d/%h exp=1/c0de000000004080", got, d); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[64'h1000 + 64'(8 * i)] = 64'hA0 + 64'(i);
        test_reset();
        test_cold_miss();
        test_store_hit();
        test_same_cycle();
        test_store_miss_order();
        test_stall();
        test_evict();
        test_reset_mid_refill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
